// File: rtl/rcg_ctrl_pkg.sv
// Shared types and constants for the divider-ratio update controller.
// Holds the FSM state encoding and the fixed settle length.
package rcg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ALN,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_ALN_RST
  } rcg_upd_state_t;

  localparam int SETTLE_CYC    = 2;
  localparam int RST_RATIO_DEF = 1;

endpackage

// File: rtl/rcg_ctrl_div_upd_if.sv
// Configuration/status and divider-bank signals of the ratio update controller.
// slave = the controller, master = register file plus divider bank.
interface rcg_ctrl_div_upd_if #(
  parameter int DIV_WIDTH = 16,
  parameter int NUM_DIV   = 4,
  parameter int TMO_WIDTH = 20
);
  logic [NUM_DIV*DIV_WIDTH-1:0] cfg_ratio;
  logic                         cfg_upd_req;
  logic                         cfg_aln_req;
  logic [TMO_WIDTH-1:0]         cfg_tmo;
  logic [NUM_DIV-1:0]           div_clk_align;
  logic [NUM_DIV*DIV_WIDTH-1:0] div_ratio;
  logic                         divider_go_pls;
  logic                         div_aln_rst_n;
  logic                         upd_busy;
  logic                         upd_done;
  logic                         upd_drop;
  logic                         aln_err;

  modport slave (
    input  cfg_ratio, cfg_upd_req, cfg_aln_req, cfg_tmo, div_clk_align,
    output div_ratio, divider_go_pls, div_aln_rst_n,
           upd_busy, upd_done, upd_drop, aln_err
  );

  modport master (
    output cfg_ratio, cfg_upd_req, cfg_aln_req, cfg_tmo, div_clk_align,
    input  div_ratio, divider_go_pls, div_aln_rst_n,
           upd_busy, upd_done, upd_drop, aln_err
  );
endinterface

// File: rtl/rcg_ctrl_tmo_cntr.sv
// Saturating per-state cycle counter with a programmable expiry compare.
// A zero limit disables expiry; the count itself never wraps.
module rcg_ctrl_tmo_cntr #(
  parameter int TMO_WIDTH = 20
) (
  input  logic                 clk_in,
  input  logic                 grst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [TMO_WIDTH-1:0] tmo_i,
  output logic [TMO_WIDTH-1:0] cnt_o,
  output logic                 expired_o
);

  logic [TMO_WIDTH-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_in or posedge grst) begin
    if (grst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o     = cnt_q;
  assign expired_o = (tmo_i != '0) && (cnt_q >= tmo_i);

endmodule

// File: rtl/rcg_ctrl_div_upd.sv
// Ratio update controller for a bank of clock dividers: waits for common
// alignment, loads new ratios with one restart pulse, then confirms realignment.
module rcg_ctrl_div_upd
  import rcg_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int NUM_DIV   = 4,
  parameter int RST_RATIO = RST_RATIO_DEF,
  parameter int TMO_WIDTH = 20,
  parameter int ALN_CYC   = 4
) (
  input  logic               clk_in,
  input  logic               grst,
  rcg_ctrl_div_upd_if.slave  bus
);

  localparam int RW = NUM_DIV * DIV_WIDTH;
  localparam logic [RW-1:0] RST_VEC = {NUM_DIV{DIV_WIDTH'(RST_RATIO)}};

  rcg_upd_state_t state_q, state_d;
  logic [RW-1:0]  shadow_q, shadow_d;
  logic [RW-1:0]  ratio_q, ratio_d;
  logic           go_q, go_d;
  logic           aln_rst_n_q, aln_rst_n_d;
  logic           busy_q;
  logic           done_q, done_d;
  logic           drop_q, drop_d;
  logic           err_q, err_d;

  logic                 all_aln;
  logic                 tmo_clr;
  logic                 tmo_en;
  logic                 tmo_expired;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  assign all_aln = &bus.div_clk_align;
  // One counter serves every timed state: it restarts on each state change.
  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = (state_q != ST_IDLE);

  rcg_ctrl_tmo_cntr #(.TMO_WIDTH(TMO_WIDTH)) u_tmo (
    .clk_in    (clk_in),
    .grst      (grst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .tmo_i     (bus.cfg_tmo),
    .cnt_o     (tmo_cnt),
    .expired_o (tmo_expired)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    state_d     = state_q;
    shadow_d    = shadow_q;
    ratio_d     = ratio_q;
    go_d        = 1'b0;
    aln_rst_n_d = 1'b1;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_aln_req) begin
          state_d     = ST_ALN_RST;
          err_d       = 1'b0;
          aln_rst_n_d = 1'b0;
          drop_d      = bus.cfg_upd_req;
        end else if (bus.cfg_upd_req) begin
          state_d  = ST_WAIT_ALN;
          shadow_d = bus.cfg_ratio;
          err_d    = 1'b0;
        end
      end
      ST_WAIT_ALN: begin
        if (all_aln) begin
          state_d = ST_LOAD;
        end else if (tmo_expired) begin
          state_d = ST_LOAD;
          err_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        ratio_d = shadow_q;
        go_d    = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmo_cnt == TMO_WIDTH'(SETTLE_CYC - 1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (all_aln) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_ALN_RST: begin
        aln_rst_n_d = 1'b0;
        if (tmo_cnt == TMO_WIDTH'(ALN_CYC - 1)) begin
          aln_rst_n_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && (bus.cfg_upd_req || bus.cfg_aln_req)) drop_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge grst) begin
    if (grst) begin
      state_q     <= ST_IDLE;
      // NOTE: the shadow bank is small and its reset value is observable
      // after an aborted update, so it is reset along with the control flops.
      shadow_q    <= '0;
      ratio_q     <= RST_VEC;
      go_q        <= 1'b0;
      aln_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      ratio_q     <= ratio_d;
      go_q        <= go_d;
      aln_rst_n_q <= aln_rst_n_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  assign bus.div_ratio      = ratio_q;
  assign bus.divider_go_pls = go_q;
  assign bus.div_aln_rst_n  = aln_rst_n_q;
  assign bus.upd_busy       = busy_q;
  assign bus.upd_done       = done_q;
  assign bus.upd_drop       = drop_q;
  assign bus.aln_err        = err_q;

endmodule

// File: tb/tb_rcg_ctrl_div_upd.sv
// Randomized bench for rcg_ctrl_div_upd: each request is predicted as a
// timeline of events (go edge, done edge, error) and every output is compared per cycle.
module tb_rcg_ctrl_div_upd;

  localparam int DW   = 16;
  localparam int ND   = 4;
  localparam int TW   = 20;
  localparam int ALN  = 4;
  localparam int RSTR = 1;
  localparam int RW   = DW * ND;
  localparam logic [RW-1:0] RST_VEC = {ND{DW'(RSTR)}};

  logic clk_in = 1'b0;
  logic grst   = 1'b1;

  rcg_ctrl_div_upd_if #(.DIV_WIDTH(DW), .NUM_DIV(ND), .TMO_WIDTH(TW)) bus ();

  rcg_ctrl_div_upd #(
    .DIV_WIDTH (DW),
    .NUM_DIV   (ND),
    .RST_RATIO (RSTR),
    .TMO_WIDTH (TW),
    .ALN_CYC   (ALN)
  ) dut (
    .clk_in (clk_in),
    .grst   (grst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [RW-1:0] cur_ratio;
  logic          cur_err;

  task automatic check(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string pfx, input logic [RW-1:0] e_ratio, input bit e_go,
                            input bit e_rstn, input bit e_busy, input bit e_done,
                            input bit e_drop, input bit e_err);
    check({pfx, ".div_ratio"}, bus.div_ratio, e_ratio);
    check({pfx, ".go"},        RW'(bus.divider_go_pls), RW'(e_go));
    check({pfx, ".aln_rst_n"}, RW'(bus.div_aln_rst_n),  RW'(e_rstn));
    check({pfx, ".busy"},      RW'(bus.upd_busy),       RW'(e_busy));
    check({pfx, ".done"},      RW'(bus.upd_done),       RW'(e_done));
    check({pfx, ".drop"},      RW'(bus.upd_drop),       RW'(e_drop));
    check({pfx, ".aln_err"},   RW'(bus.aln_err),        RW'(e_err));
  endtask

  function automatic logic [ND-1:0] align_pat(input bit aligned, input int lo_bit);
    logic [ND-1:0] p;
    p = ND'($urandom);
    if (aligned) p = '1;
    else         p[lo_bit] = 1'b0;
    return p;
  endfunction

  function automatic logic [RW-1:0] rand_ratios();
    logic [RW-1:0] r;
    for (int i = 0; i < ND; i++) begin
      if ($urandom_range(0, 3) == 0) r[i*DW +: DW] = DW'($urandom_range(0, 1));
      else                           r[i*DW +: DW] = DW'($urandom);
    end
    return r;
  endfunction

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check_outs("idle", cur_ratio, 0, 1, 0, 0, 0, cur_err);
      bus.div_clk_align = align_pat($urandom_range(0, 1) == 1, 0);
    end
  endtask

  // drop_at: -1 none, 0 pick a random busy edge, >0 that edge (edge 0 samples the request).
  // Dividers stay misaligned for dw cycles of the wait phase and dc cycles of the check phase.
  task automatic run_upd(input logic [RW-1:0] r, input int tmo, input int dw, input int dc,
                         input int drop_at, input int lo_bit);
    int w, c, t_go, t_done, d;
    bit err_w, err_c, e_err;
    logic [RW-1:0] e_ratio;
    err_w  = (tmo != 0) && (dw > tmo);
    w      = err_w ? tmo : dw;
    err_c  = (tmo != 0) && (dc > tmo);
    c      = err_c ? tmo : dc;
    t_go   = w + 2;
    t_done = w + 5 + c;
    d      = (drop_at == 0) ? int'($urandom_range(1, t_done)) : drop_at;

    bus.cfg_ratio     = r;
    bus.cfg_tmo       = TW'(tmo);
    bus.cfg_upd_req   = 1'b1;
    bus.cfg_aln_req   = 1'b0;
    bus.div_clk_align = align_pat($urandom_range(0, 1) == 1, lo_bit);
    for (int n = 0; n <= t_done; n++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      bus.cfg_upd_req = 1'b0;
      bus.cfg_aln_req = 1'b0;
      e_ratio = (n >= t_go) ? r : cur_ratio;
      if (n <= w)          e_err = 1'b0;
      else if (n < t_done) e_err = err_w;
      else                 e_err = err_w | err_c;
      check_outs("upd", e_ratio, n == t_go, 1, n < t_done, n == t_done, n == d, e_err);
      if (n <= w)          bus.div_clk_align = align_pat(n >= dw, lo_bit);
      else if (n <= w + 3) bus.div_clk_align = align_pat($urandom_range(0, 1) == 1, lo_bit);
      else                 bus.div_clk_align = align_pat((n - w - 4) >= dc, lo_bit);
      if (n + 1 == d) begin
        if ($urandom_range(0, 1) == 1) bus.cfg_upd_req = 1'b1;
        else                           bus.cfg_aln_req = 1'b1;
        bus.cfg_ratio = rand_ratios();
      end
    end
    cur_ratio = r;
    cur_err   = err_w | err_c;
  endtask

  task automatic run_aln(input bit both, input int drop_at);
    int d;
    d = (drop_at == 0) ? int'($urandom_range(1, ALN)) : drop_at;
    bus.cfg_ratio   = rand_ratios();
    bus.cfg_aln_req = 1'b1;
    bus.cfg_upd_req = both;
    for (int n = 0; n <= ALN; n++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      bus.cfg_upd_req = 1'b0;
      bus.cfg_aln_req = 1'b0;
      check_outs("aln", cur_ratio, 0, n >= ALN, n < ALN, n == ALN,
                 (n == 0 && both) || n == d, 0);
      bus.div_clk_align = align_pat($urandom_range(0, 1) == 1, 0);
      if (n + 1 == d) bus.cfg_upd_req = 1'b1;
    end
    cur_err = 1'b0;
  endtask

  task automatic run_reset_mid_wait();
    bus.cfg_ratio     = rand_ratios();
    bus.cfg_tmo       = '0;
    bus.cfg_upd_req   = 1'b1;
    bus.div_clk_align = align_pat(0, 1);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      bus.cfg_upd_req = 1'b0;
      check_outs("rst_wait", cur_ratio, 0, 1, 1, 0, 0, 0);
      bus.div_clk_align = align_pat(0, 1);
    end
    #2 grst = 1'b1;
    bus.div_clk_align = '1;
    #1 check_outs("rst_async", RST_VEC, 0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check_outs("rst_hold", RST_VEC, 0, 1, 0, 0, 0, 0);
    end
    grst      = 1'b0;
    cur_ratio = RST_VEC;
    cur_err   = 1'b0;
  endtask

  initial begin
    bus.cfg_ratio     = '0;
    bus.cfg_upd_req   = 1'b0;
    bus.cfg_aln_req   = 1'b0;
    bus.cfg_tmo       = '0;
    bus.div_clk_align = '1;
    cur_ratio         = RST_VEC;
    cur_err           = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_outs("reset", RST_VEC, 0, 1, 0, 0, 0, 0);
    grst = 1'b0;
    idle_cycles(3);

    run_upd({16'd4, 16'd4, 16'd2, 16'd2}, 0, 0, 0, -1, 0);
    idle_cycles(1);
    run_upd(rand_ratios(), 100, 1000, 0, -1, 2);
    idle_cycles(1);
    run_upd(rand_ratios(), 0, 3, 1, -1, 0);
    run_aln(0, -1);
    run_aln(1, 2);
    run_upd({16'd0, 16'd1, 16'd7, 16'd3}, 0, 0, 0, 3, 1);
    idle_cycles(2);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 9) < 7) begin
        run_upd(rand_ratios(),
                ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)),
                int'($urandom_range(0, 25)), int'($urandom_range(0, 8)),
                ($urandom_range(0, 2) == 0) ? 0 : -1,
                int'($urandom_range(0, ND - 1)));
      end else begin
        run_aln($urandom_range(0, 3) == 0, ($urandom_range(0, 2) == 0) ? 0 : -1);
      end
      idle_cycles(int'($urandom_range(0, 3)));
    end

    run_reset_mid_wait();
    idle_cycles(2);
    run_upd(rand_ratios(), 10, 2, 0, -1, 3);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rcg_ctrl_div_upd.md
Name: rcg_ctrl_div_upd

Overview:
- Upstream control stage for a bank of NUM_DIV clock divider counters. It owns their div_ratio, divider_go_pls and div_aln_rst_n inputs.
- Accepts a new ratio set from the configuration side.
- Waits for a common alignment point of all dividers, then loads the new ratios with a single restart pulse.
- Confirms that all dividers realign, and reports done or error status back to the register file.

Parameters:
- DIV_WIDTH, 16, width of each divider ratio.
- NUM_DIV, 4, number of dividers controlled.
- RST_RATIO, 1, ratio driven to every divider out of reset (1 = bypass).
- TMO_WIDTH, 20, width of the alignment timeout counter.
- ALN_CYC, 4, cycles div_aln_rst_n is held low on an align request.

Ports:
- clk_in  in  1  high-speed source clock shared with all dividers.
- grst  in  1  asynchronous active-high reset.
- cfg_ratio  in  NUM_DIV*DIV_WIDTH  requested ratios; divider i uses slice [i*DIV_WIDTH +: DIV_WIDTH].
- cfg_upd_req  in  1  single-cycle pulse requesting a ratio update.
- cfg_aln_req  in  1  single-cycle pulse requesting a forced alignment reset.
- cfg_tmo  in  TMO_WIDTH  alignment timeout in cycles; 0 means no timeout.
- div_clk_align  in  NUM_DIV  per-divider end-of-period indication returned by the dividers.
- div_ratio  out  NUM_DIV*DIV_WIDTH  registered ratios to the dividers.
- divider_go_pls  out  1  registered one-cycle restart pulse to all dividers.
- div_aln_rst_n  out  1  registered active-low alignment reset to all dividers.
- upd_busy  out  1  high while the FSM is not in IDLE.
- upd_done  out  1  one-cycle pulse when an update or alignment completes.
- upd_drop  out  1  one-cycle pulse when a request is ignored because upd_busy is high.
- aln_err  out  1  sticky error flag; cleared only by grst or by the next accepted request.

Behaviour:
- Reset (grst high, asynchronous) forces:
  - div_ratio = RST_RATIO in every slice;
  - divider_go_pls = 0, div_aln_rst_n = 1;
  - upd_busy = 0, upd_done = 0, upd_drop = 0, aln_err = 0;
  - FSM = IDLE, timeout counter = 0, shadow register = 0.
- Reset asserted mid-operation aborts the update. No go pulse is issued and the ratios return to RST_RATIO.
- all_aln is the AND of div_clk_align[NUM_DIV-1:0], taken combinationally.
- FSM states: IDLE, WAIT_ALN, LOAD, SETTLE, CHECK, ALN_RST.
- IDLE:
  - cfg_upd_req captures cfg_ratio into the shadow register, clears aln_err and moves to WAIT_ALN.
  - cfg_aln_req moves to ALN_RST and clears aln_err.
  - If both arrive in the same cycle, cfg_aln_req wins and the update request is dropped with upd_drop = 1.
- WAIT_ALN:
  - all_aln = 1 moves to LOAD.
  - Otherwise the timeout counter increments.
  - When the counter reaches cfg_tmo (cfg_tmo != 0), set aln_err and still move to LOAD (forced load).
- LOAD (one cycle): on the next edge div_ratio = shadow and divider_go_pls = 1 for exactly one cycle. Then SETTLE.
- SETTLE: wait 2 cycles so the dividers restart their counters. Then CHECK, with the timeout counter cleared.
- CHECK:
  - all_aln = 1 pulses upd_done and returns to IDLE.
  - Timeout sets aln_err, pulses upd_done and returns to IDLE.
- ALN_RST:
  - div_aln_rst_n = 0 for ALN_CYC cycles.
  - Release, pulse upd_done, return to IDLE. div_ratio is unchanged.
- Any cfg_upd_req or cfg_aln_req arriving while upd_busy = 1 is ignored and produces upd_drop = 1 in the following cycle.
- Timeout counter:
  - Clears on every state entry.
  - Saturates at its maximum value and never wraps.
  - With cfg_tmo = 0 it never expires.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: cfg_upd_req with all_aln already high gives divider_go_pls 2 cycles later.
- Ratio values 0 and 1 are passed through unchanged; the divider treats both as bypass.

Decomposition:
- Shared package rcg_ctrl_pkg holds:
  - the FSM state encoding typedef (rcg_upd_state_t);
  - SETTLE_CYC = 2;
  - the default RST_RATIO constant.
- One sub-module, rcg_ctrl_tmo_cntr: a saturating timeout counter with clear/enable, compare to cfg_tmo and an expired output. Reused by WAIT_ALN and CHECK.

Test Plan:
- Reset release, no requests → div_ratio = 0x0001 in all 4 slices, div_aln_rst_n = 1, upd_busy = 0, all pulses 0.
- all_aln held 1, cfg_upd_req with ratios {4,4,2,2} → divider_go_pls high exactly one cycle 2 cycles after the request, div_ratio updated on that same edge, upd_done after CHECK sees all_aln, aln_err = 0.
- div_clk_align[2] held 0, cfg_tmo = 100, update request → forced load after 100 cycles in WAIT_ALN, aln_err = 1, go pulse still issued; the next request clears aln_err.
- cfg_aln_req with ALN_CYC = 4 → div_aln_rst_n low exactly 4 cycles, div_ratio unchanged, then upd_done.
- Second cfg_upd_req during SETTLE → upd_drop pulse, shadow not overwritten, first update completes with the original values.
- grst asserted during WAIT_ALN → immediate return to reset values, no divider_go_pls; after release the FSM is in IDLE and accepts a new request.
